int_ctrl: RTL and testbench

Interrupt controller for the pipelined MIPS core. It collects up to N_SRC external interrupt lines and latches their rising edges as pending requests. It applies a software-writable enable mask and picks the highest-priority enabled request. It then runs a request/acknowledge/return handshake with the CPU, which drives the core's single `INT` input. While the handshake runs it supplies the handler vector and cause ID, and it blocks further requests until the handler executes `eret`.

---
 rtl/int_ctrl.sv | 161 ++++++++++++++++
 tb/tb_int_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller for the pipelined MIPS core.
// Rising edges on irq_in are latched as pending requests. A software mask
// gates them, and the lowest enabled index wins. The winner is then presented
// to the CPU through a REQ -> SERVICE -> IDLE handshake (int_ack / eret).
// There is no nesting: edges that arrive during a handshake are only latched
// and wait for the controller to return to IDLE.
module int_ctrl #(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0040,
    parameter int          VEC_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             eret,
    output logic             int_req,
    output logic [2:0]       int_cause,
    output logic [31:0]      int_vec,
    output logic             in_service,
    output logic [N_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N_SRC-1:0] r_irq_d;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_pending;
    logic             r_int_req;
    logic             r_in_service;
    logic [2:0]       r_cause;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_enabled;
    logic             w_ack_taken;
    logic [2:0]       w_winner;

    // Lowest set index of a request vector; callers only use it when non-zero.
    function automatic logic [2:0] pick_lowest(input logic [N_SRC-1:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign w_rise      = irq_in & ~r_irq_d;
    assign w_enabled   = r_pending & r_mask;
    assign w_ack_taken = (r_state == S_REQ) && int_ack;
    assign w_winner    = pick_lowest(w_enabled);

    // One-hot clear of the source being acknowledged; only active on a legal ack.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_ack_taken && (r_cause == 3'(i))) begin
                w_clr[i] = 1'b1;
            end else begin
                w_clr[i] = 1'b0;
            end
        end
    end

    // Delayed copy of the irq lines for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq_d <= '0;
        end else begin
            r_irq_d <= irq_in;
        end
    end

    // Software enable mask; resets to all sources enabled, writable in any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= {N_SRC{1'b1}};
        end else if (mask_we) begin
            r_mask <= mask_wdata;
        end else begin
            r_mask <= r_mask;
        end
    end

    // Pending latch: a new edge beats a same-cycle acknowledge clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    // Handshake FSM with registered int_req / in_service / int_cause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_int_req    <= 1'b0;
            r_in_service <= 1'b0;
            r_cause      <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_service <= 1'b0;
                    if (|w_enabled) begin
                        r_cause   <= w_winner;
                        r_int_req <= 1'b1;
                        r_state   <= S_REQ;
                    end else begin
                        r_int_req <= 1'b0;
                    end
                end
                S_REQ: begin
                    // Cause stays frozen here; later mask writes do not retract it.
                    if (int_ack) begin
                        r_int_req    <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= S_SERVICE;
                    end else begin
                        r_int_req    <= 1'b1;
                        r_in_service <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    r_int_req <= 1'b0;
                    if (eret) begin
                        r_in_service <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_in_service <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_int_req    <= 1'b0;
                    r_in_service <= 1'b0;
                    r_cause      <= 3'd0;
                end
            endcase
        end
    end

    assign int_req    = r_int_req;
    assign in_service = r_in_service;
    assign int_cause  = r_cause;
    assign pending    = r_pending;
    assign int_vec    = VEC_BASE + (32'(r_cause) << VEC_SHIFT);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, single request, priority, masking,
// non-nesting, set-wins on same-cycle ack, spurious handshakes, async reset.
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_in;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        int_ack;
    logic        eret;
    logic        int_req;
    logic [2:0]  int_cause;
    logic [31:0] int_vec;
    logic        in_service;
    logic [3:0]  pending;

    int n_cmp;
    int n_bad;

    int_ctrl #(
        .N_SRC     (4),
        .VEC_BASE  (32'h0000_0040),
        .VEC_SHIFT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_cause  (int_cause),
        .int_vec    (int_vec),
        .in_service (in_service),
        .pending    (pending)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic req, input logic svc,
                              input logic [2:0] cause, input logic [31:0] vec,
                              input logic [3:0] pend);
        check_eq({tag, ".req"},   32'(int_req),    32'(req));
        check_eq({tag, ".svc"},   32'(in_service), 32'(svc));
        check_eq({tag, ".cause"}, 32'(int_cause),  32'(cause));
        check_eq({tag, ".vec"},   int_vec,         vec);
        check_eq({tag, ".pend"},  32'(pending),    32'(pend));
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        irq_in     = 4'b0000;
        mask_we    = 1'b0;
        mask_wdata = 4'b0000;
        int_ack    = 1'b0;
        eret       = 1'b0;

        // Reset held for two cycles
        step(); step();
        expect_out("rst", 1'b0, 1'b0, 3'd0, 32'h40, 4'b0000);
        rst = 1'b1;
        step();

        // Single request on source 2 (default mask enables it)
        irq_in = 4'b0100;
        step();
        expect_out("s1_pend", 1'b0, 1'b0, 3'd0, 32'h40, 4'b0100);
        step();
        expect_out("s1_req", 1'b1, 1'b0, 3'd2, 32'h60, 4'b0100);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_out("s1_ack", 1'b0, 1'b1, 3'd2, 32'h60, 4'b0000);
        eret = 1'b1; step(); eret = 1'b0;
        expect_out("s1_eret", 1'b0, 1'b0, 3'd2, 32'h60, 4'b0000);
        step();
        expect_out("s1_level", 1'b0, 1'b0, 3'd2, 32'h60, 4'b0000);
        irq_in = 4'b0000;
        step();

        // Priority: sources 3 and 1 together, 1 first
        irq_in = 4'b1010;
        step();
        check_eq("pr_pend", 32'(pending), 32'h0000_000A);
        step();
        expect_out("pr_req1", 1'b1, 1'b0, 3'd1, 32'h50, 4'b1010);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_out("pr_ack1", 1'b0, 1'b1, 3'd1, 32'h50, 4'b1000);
        eret = 1'b1; step(); eret = 1'b0;
        check_eq("pr_gap", 32'(int_req), 32'd0);
        step();
        expect_out("pr_req3", 1'b1, 1'b0, 3'd3, 32'h70, 4'b1000);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
        irq_in = 4'b0000;
        step();
        expect_out("pr_done", 1'b0, 1'b0, 3'd3, 32'h70, 4'b0000);

        // Masking source 0
        mask_we = 1'b1; mask_wdata = 4'b1110; step(); mask_we = 1'b0;
        irq_in = 4'b0001;
        step();
        check_eq("mk_pend", 32'(pending), 32'h1);
        step(); step();
        check_eq("mk_blocked", 32'(int_req), 32'd0);
        mask_we = 1'b1; mask_wdata = 4'b1111; step(); mask_we = 1'b0;
        check_eq("mk_lat1", 32'(int_req), 32'd0);
        step();
        expect_out("mk_req", 1'b1, 1'b0, 3'd0, 32'h40, 4'b0001);

        // Spurious eret while in REQ
        eret = 1'b1; step(); eret = 1'b0;
        expect_out("sp_eret", 1'b1, 1'b0, 3'd0, 32'h40, 4'b0001);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_out("mk_ack", 1'b0, 1'b1, 3'd0, 32'h40, 4'b0000);

        // Non-nesting: source 1 rises during SERVICE of source 0
        irq_in = 4'b0011;
        step();
        expect_out("nn_pend", 1'b0, 1'b1, 3'd0, 32'h40, 4'b0010);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_out("nn_hold", 1'b0, 1'b1, 3'd0, 32'h40, 4'b0010);
        eret = 1'b1; step(); eret = 1'b0;
        check_eq("nn_gap", 32'(int_req), 32'd0);
        step();
        expect_out("nn_req1", 1'b1, 1'b0, 3'd1, 32'h50, 4'b0010);

        // Set-wins: new source-1 edge in the same cycle as its ack
        irq_in = 4'b0000;
        step();
        irq_in  = 4'b0010;
        int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_out("sw_ack", 1'b0, 1'b1, 3'd1, 32'h50, 4'b0010);
        eret = 1'b1; step(); eret = 1'b0;
        step();
        expect_out("sw_req2", 1'b1, 1'b0, 3'd1, 32'h50, 4'b0010);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
        irq_in = 4'b0000;
        step();
        expect_out("sw_done", 1'b0, 1'b0, 3'd1, 32'h50, 4'b0000);

        // Spurious ack in IDLE with a masked pending source 2
        mask_we = 1'b1; mask_wdata = 4'b1011; step(); mask_we = 1'b0;
        irq_in = 4'b0100;
        step();
        int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_out("sp_ack", 1'b0, 1'b0, 3'd1, 32'h50, 4'b0100);

        // Unmask, take it into SERVICE, then async reset
        mask_we = 1'b1; mask_wdata = 4'b1111; step(); mask_we = 1'b0;
        step();
        expect_out("ar_req", 1'b1, 1'b0, 3'd2, 32'h60, 4'b0100);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        check_eq("ar_svc", 32'(in_service), 32'd1);
        irq_in = 4'b0000;
        #2 rst = 1'b0;
        #1;
        expect_out("ar_async", 1'b0, 1'b0, 3'd0, 32'h40, 4'b0000);
        step();
        rst = 1'b1;
        step();
        expect_out("ar_after", 1'b0, 1'b0, 3'd0, 32'h40, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
